// File: rtl/player_anim_pkg.sv
// player_anim_pkg
// Shared definitions for the player animation path (sequencer and sprite
// mapper): state encodings, default animation lengths and the sprite size.
// No ports; import with "import player_anim_pkg::*;".
package player_anim_pkg;

  // Encodings are shared with player_sprite_mapper; value 2 is reserved.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_MOVE = 4'd1,
    S_ATK1 = 4'd3,
    S_ATK2 = 4'd4,
    S_HIT  = 4'd5
  } anim_state_e;

  localparam int FRAME_W             = 6;
  localparam int DEF_TICK_DIV        = 4;
  localparam int DEF_IDLE_FRAMES     = 10;
  localparam int DEF_RUN_FRAMES      = 8;
  localparam int DEF_ATK1_FRAMES     = 18;
  localparam int DEF_ATK2_FRAMES     = 12;
  localparam int DEF_HIT_FRAMES      = 6;
  localparam int DEF_ATK1_HIT_START  = 8;
  localparam int DEF_ATK1_HIT_END    = 11;

  // Sprite cell edge length in pixels.
  localparam int SPRITE_SIZE         = 126;

endpackage

// File: rtl/player_anim_sequencer_tick_div.sv
// anim_tick_div
// Divides the per-video-frame tick down to animation frame steps.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clr         - synchronous clear of the divider (state change/restart)
//   frame_tick  - one-cycle pulse per video frame
//   step        - one-cycle pulse on the TICK_DIV-th frame_tick
module anim_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic frame_tick,
  output logic step
);

  localparam logic [3:0] LAST = 4'(TICK_DIV - 1);

  logic [3:0] cnt_q;

  assign step = frame_tick && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (frame_tick) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/player_anim_sequencer.sv
// player_anim_sequencer
// Per-player animation state machine feeding player_sprite_mapper.
// Ports:
//   clk, reset        - game-logic clock, synchronous active-high reset
//   frame_tick        - one-cycle pulse per video frame
//   btn_left/right    - debounced direction levels
//   btn_atk1/atk2     - debounced attack request levels
//   hit_in            - one-cycle pulse: player was struck
//   anim_state        - current state encoding (player_anim_pkg)
//   anim_frame        - frame index within the current state
//   facing_right      - 1 = facing right
//   attack_active     - attack1 hitbox live
//   busy              - in a one-shot (ATK1/ATK2/HIT)
//   anim_done         - one-cycle pulse when a one-shot finishes
// Build option: define ATK_COMBO_EN to chain ATK1 into ATK2 when btn_atk1 is
// pressed during the ATK1 recovery frames.
module player_anim_sequencer
  import player_anim_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int IDLE_FRAMES    = DEF_IDLE_FRAMES,
  parameter int RUN_FRAMES     = DEF_RUN_FRAMES,
  parameter int ATK1_FRAMES    = DEF_ATK1_FRAMES,
  parameter int ATK2_FRAMES    = DEF_ATK2_FRAMES,
  parameter int HIT_FRAMES     = DEF_HIT_FRAMES,
  parameter int ATK1_HIT_START = DEF_ATK1_HIT_START,
  parameter int ATK1_HIT_END   = DEF_ATK1_HIT_END,
  parameter int INIT_FACING    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_atk1,
  input  logic       btn_atk2,
  input  logic       hit_in,
  output logic [3:0] anim_state,
  output logic [5:0] anim_frame,
  output logic       facing_right,
  output logic       attack_active,
  output logic       busy,
  output logic       anim_done
);

  localparam logic [5:0] HIT_START = 6'(ATK1_HIT_START);
  localparam logic [5:0] HIT_END   = 6'(ATK1_HIT_END);

  anim_state_e state_q, state_d;
  logic [5:0]  frame_q, frame_d;
  logic        facing_q, facing_d;
  logic        active_q, active_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        restart;
  logic        step;
`ifdef ATK_COMBO_EN
  logic        combo_q, combo_d;
  logic        combo_set;
`endif

  function automatic logic [5:0] last_frame(input anim_state_e s);
    case (s)
      S_IDLE:  return 6'(IDLE_FRAMES - 1);
      S_MOVE:  return 6'(RUN_FRAMES - 1);
      S_ATK1:  return 6'(ATK1_FRAMES - 1);
      S_ATK2:  return 6'(ATK2_FRAMES - 1);
      S_HIT:   return 6'(HIT_FRAMES - 1);
      default: return 6'd0;
    endcase
  endfunction

  // Divider is cleared whenever the state is (re)entered so every state
  // starts with a full TICK_DIV period on frame 0.
  anim_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk        (clk),
    .reset      (reset),
    .clr        (restart),
    .frame_tick (frame_tick),
    .step       (step)
  );

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    facing_d = facing_q;
    done_d   = 1'b0;
    restart  = 1'b0;
`ifdef ATK_COMBO_EN
    combo_d   = combo_q;
    combo_set = (state_q == S_ATK1) && btn_atk1 && (frame_q > HIT_END);
`endif

    if (hit_in) begin
      // Hit wins over everything, and re-entering HIT restarts it.
      state_d = S_HIT;
      restart = 1'b1;
`ifdef ATK_COMBO_EN
      combo_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_MOVE: begin
          if (btn_left ^ btn_right) facing_d = btn_right;
          if (btn_atk1)                  state_d = S_ATK1;
          else if (btn_atk2)             state_d = S_ATK2;
          else if (btn_left ^ btn_right) state_d = S_MOVE;
          else                           state_d = S_IDLE;
          if (state_d != state_q) begin
            restart = 1'b1;
          end else if (step) begin
            if (frame_q == last_frame(state_q)) frame_d = '0;
            else                                frame_d = frame_q + 6'd1;
          end
        end
        S_ATK1, S_ATK2, S_HIT: begin
`ifdef ATK_COMBO_EN
          if (combo_set) combo_d = 1'b1;
`endif
          if (step) begin
            if (frame_q == last_frame(state_q)) begin
              done_d  = 1'b1;
              restart = 1'b1;
              state_d = S_IDLE;
`ifdef ATK_COMBO_EN
              if (state_q == S_ATK1 && (combo_q || combo_set)) state_d = S_ATK2;
              combo_d = 1'b0;
`endif
            end else begin
              frame_d = frame_q + 6'd1;
            end
          end
        end
        default: begin
          // Unused encodings recover to IDLE.
          state_d = S_IDLE;
          restart = 1'b1;
        end
      endcase
    end

    if (restart) frame_d = '0;

    // Hitbox and busy are derived from the next state so they stay aligned
    // with anim_state/anim_frame on the output registers.
    active_d = (state_d == S_ATK1) && (frame_d >= HIT_START) && (frame_d <= HIT_END);
    busy_d   = (state_d == S_ATK1) || (state_d == S_ATK2) || (state_d == S_HIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      facing_q <= 1'(INIT_FACING);
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ATK_COMBO_EN
      combo_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      facing_q <= facing_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ATK_COMBO_EN
      combo_q  <= combo_d;
`endif
    end
  end

  assign anim_state    = state_q;
  assign anim_frame    = frame_q;
  assign facing_right  = facing_q;
  assign attack_active = active_q;
  assign busy          = busy_q;
  assign anim_done     = done_q;

endmodule

// File: tb/tb_player_anim_sequencer.sv
// tb_player_anim_sequencer
// Directed bench for player_anim_sequencer with default parameters
// (TICK_DIV=4). Follows ATK_COMBO_EN the same way as the RTL.
module tb_player_anim_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_atk1 = 1'b0;
  logic       btn_atk2 = 1'b0;
  logic       hit_in = 1'b0;
  logic [3:0] anim_state;
  logic [5:0] anim_frame;
  logic       facing_right;
  logic       attack_active;
  logic       busy;
  logic       anim_done;

  int checks = 0;
  int failures = 0;

  player_anim_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_atk1      (btn_atk1),
    .btn_atk2      (btn_atk2),
    .hit_in        (hit_in),
    .anim_state    (anim_state),
    .anim_frame    (anim_frame),
    .facing_right  (facing_right),
    .attack_active (attack_active),
    .busy          (busy),
    .anim_done     (anim_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Tick whose edge is observed directly (to catch anim_done pulses).
  task automatic tick_edge();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic check_state(input string tag, input int st, input int fr);
    check({tag, "_state"}, int'(anim_state), st);
    check({tag, "_frame"}, int'(anim_frame), fr);
  endtask

  initial begin
    // Reset
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check_state("reset", 0, 0);
    check("reset_facing", int'(facing_right), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_active", int'(attack_active), 0);
    check("reset_done", int'(anim_done), 0);

    // Idle loop: a step every 4th tick
    ticks(3);
    check_state("idle_t3", 0, 0);
    ticks(1);
    check_state("idle_t4", 0, 1);
    ticks(16);
    check_state("idle_t20", 0, 5);
    check("idle_facing", int'(facing_right), 1);

    // Move left: loop of 8 frames
    btn_left = 1'b1;
    cyc();
    check_state("move_enter", 1, 0);
    check("move_facing", int'(facing_right), 0);
    ticks(28);
    check_state("move_t28", 1, 7);
    ticks(4);
    check_state("move_wrap", 1, 0);
    btn_left = 1'b0;
    cyc();
    check_state("move_release", 0, 0);

    // ATK1 full run, with atk2+right held late in the attack
    btn_atk1 = 1'b1;
    cyc();
    btn_atk1 = 1'b0;
    check_state("atk1_enter", 3, 0);
    check("atk1_busy", int'(busy), 1);
    ticks(28);
    check("atk1_f7_active", int'(attack_active), 0);
    ticks(4);
    check_state("atk1_t32", 3, 8);
    check("atk1_f8_active", int'(attack_active), 1);
    ticks(15);
    check_state("atk1_t47", 3, 11);
    check("atk1_f11_active", int'(attack_active), 1);
    ticks(1);
    check_state("atk1_t48", 3, 12);
    check("atk1_f12_active", int'(attack_active), 0);
    btn_atk2 = 1'b1;
    btn_right = 1'b1;
    cyc();
    check_state("atk1_ignore_btn", 3, 12);
    check("atk1_facing_frozen", int'(facing_right), 0);
    ticks(23);
    check_state("atk1_t71", 3, 17);
    tick_edge();
    check_state("atk1_end", 0, 0);
    check("atk1_done", int'(anim_done), 1);
    check("atk1_end_busy", int'(busy), 0);
    cyc();
    check("atk1_done_clr", int'(anim_done), 0);
    check_state("atk2_retrig", 4, 0);
    btn_atk2 = 1'b0;
    btn_right = 1'b0;

    // ATK2 runs 12 frames
    ticks(47);
    check_state("atk2_t47", 4, 11);
    tick_edge();
    check_state("atk2_end", 0, 0);
    check("atk2_done", int'(anim_done), 1);
    cyc();

    // Hit interrupts ATK1 in its hit window, then a hit restarts HIT
    btn_atk1 = 1'b1;
    cyc();
    btn_atk1 = 1'b0;
    ticks(36);
    check_state("atk1_f9", 3, 9);
    check("atk1_f9_active", int'(attack_active), 1);
    hit_in = 1'b1;
    cyc();
    hit_in = 1'b0;
    check_state("hit_enter", 5, 0);
    check("hit_active", int'(attack_active), 0);
    check("hit_busy", int'(busy), 1);
    ticks(12);
    check_state("hit_f3", 5, 3);
    hit_in = 1'b1;
    cyc();
    hit_in = 1'b0;
    check_state("hit_restart", 5, 0);
    ticks(23);
    check_state("hit_t23", 5, 5);
    tick_edge();
    check_state("hit_end", 0, 0);
    check("hit_done", int'(anim_done), 1);
    cyc();

    // Both directions held -> IDLE, facing held
    btn_left = 1'b1;
    cyc();
    check("left_facing", int'(facing_right), 0);
    btn_right = 1'b1;
    cyc();
    check_state("both_idle", 0, 0);
    check("both_facing", int'(facing_right), 0);
    btn_left = 1'b0;
    btn_right = 1'b0;
    cyc();

    // Reset mid-attack
    btn_atk1 = 1'b1;
    cyc();
    btn_atk1 = 1'b0;
    ticks(10);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_state("rst_mid_atk", 0, 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_facing", int'(facing_right), 1);

    // btn_atk1 pressed at ATK1 frame 14
    btn_atk1 = 1'b1;
    cyc();
    btn_atk1 = 1'b0;
    ticks(56);
    check_state("combo_f14", 3, 14);
    btn_atk1 = 1'b1;
    cyc();
    btn_atk1 = 1'b0;
    ticks(15);
    check_state("combo_f17", 3, 17);
    tick_edge();
    check("combo_done", int'(anim_done), 1);
`ifdef ATK_COMBO_EN
    check_state("combo_end", 4, 0);
    check("combo_busy", int'(busy), 1);
`else
    check_state("combo_end", 0, 0);
    check("combo_busy", int'(busy), 0);
`endif
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
